riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
Load/store unit sitting directly downstream of the execute stage (ALU computes effective address) and upstream of register write-back. Accepts one memory op at a time, drives the data-memory bus with a request/acknowledge handshake that tolerates wait states, aligns/sign-extends load data, and presents a write-back result. Stalls the core while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUS waiting for dack_i before abort (used only with RISCV_LSU_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  reset, asynchronous, active-high
ex_valid_i  in  1  execute stage presents an op this cycle
ex_ready_o  out  1  LSU can accept an op (high only in IDLE)
ex_load_i  in  1  op is a load
ex_store_i  in  1  op is a store
ex_size_i  in  2  0=byte, 1=half, 2=word (3 treated as word)
ex_unsigned_i  in  1  zero-extend load (LBU/LHU)
ex_addr_i  in  32  effective address from ALU
ex_wdata_i  in  32  store data (rs2), low bits significant
ex_rd_i  in  5  load destination register
daddr_o  out  32  bus address, word-aligned (addr[1:0]=0)
dwdata_o  out  32  store data replicated to all lanes (byte x4, half x2)
dmask_o  out  4  byte-lane enables
dsize_o  out  2  access size, same encoding as ex_size_i
drd_o  out  1  read strobe
dwr_o  out  1  write strobe
drdata_i  in  32  read data, valid when dack_i high
dack_i  in  1  bus acknowledge, one-cycle pulse
wb_valid_o  out  1  one-cycle pulse: load result valid
wb_rd_o  out  5  load destination
wb_value_o  out  32  aligned, extended load data
stall_o  out  1  hold upstream pipeline
misalign_o  out  1  one-cycle pulse: misaligned op rejected
bus_err_o  out  1  one-cycle pulse: bus timeout abort

Behaviour:
- Reset (async, reset_i=1): state=IDLE; all outputs 0 except ex_ready_o=1; captured registers cleared. Reset mid-access drops drd_o/dwr_o immediately; no wb pulse follows.
- FSM states: IDLE, BUS, RESP.
- IDLE: ex_ready_o=1. Accept when ex_valid_i & (ex_load_i|ex_store_i). Load has priority if both asserted (treated as load). ex_valid_i with neither: ignored.
- Alignment check in IDLE: half needs addr[0]=0; word needs addr[1:0]=0. Misaligned -> no bus access, misalign_o=1 next cycle, remain IDLE.
- Aligned accept: register addr/size/unsigned/rd/wdata; next cycle -> BUS.
- BUS: drd_o (load) or dwr_o (store) held high; daddr_o/dwdata_o/dmask_o/dsize_o stable until dack_i. dmask_o: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- dack_i in BUS: strobes drop next cycle. Load -> capture lane-selected drdata_i, sign/zero-extend, go RESP. Store -> IDLE.
- RESP: wb_valid_o=1 for exactly one cycle with wb_rd_o/wb_value_o; -> IDLE. wb_value_o/wb_rd_o hold last value otherwise.
- rd=0 load: bus access performed, wb pulse issued with wb_rd_o=0 (regfile discards).
- dack_i outside BUS ignored.
- stall_o = (state!=IDLE) | (ex_valid_i & aligned accept this cycle).
- Latency with zero-wait bus (dack_i in first BUS cycle): accept cycle N, BUS N+1, wb_valid_o N+2; store frees ex_ready_o at N+2.

Optional Feature:
RISCV_LSU_TIMEOUT_EN: defined -> counter starts at 0 on entering BUS, increments each BUS cycle without dack_i; reaching TIMEOUT_CYCLES drops strobes, pulses bus_err_o one cycle, returns IDLE, no wb pulse. Undefined -> BUS waits indefinitely; bus_err_o tied 0; no counter logic.

Test Plan:
- LW addr 0x100, dack_i on first BUS cycle, drdata_i=0xDEADBEEF -> daddr_o=0x100, dmask_o=1111, wb_valid_o at accept+2, wb_value_o=0xDEADBEEF.
- LB addr 0x203, drdata_i=0x80112233 -> dmask_o=1000, wb_value_o=0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr 0x42, wdata=0x0000ABCD, dack_i after 3 wait cycles -> dwdata_o=0xABCDABCD, dmask_o=1100, dwr_o high 4 cycles, stall_o high throughout, no wb_valid_o.
- LW addr 0x102 -> misalign_o pulse, drd_o never asserts, ex_ready_o stays 1.
- Reset asserted during BUS of a load -> drd_o falls without clock edge, no wb_valid_o, state IDLE after release.
- With RISCV_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, dack_i never asserted -> bus_err_o pulse after 4 BUS cycles, strobes drop, ex_ready_o=1.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding data-memory access, lane alignment and load extension.
// Optional bus timeout abort is compiled in with `define RISCV_LSU_TIMEOUT_EN.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_load_i,
    input  logic        ex_store_i,
    input  logic [1:0]  ex_size_i,
    input  logic        ex_unsigned_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [4:0]  ex_rd_i,
    output logic [31:0] daddr_o,
    output logic [31:0] dwdata_o,
    output logic [3:0]  dmask_o,
    output logic [1:0]  dsize_o,
    output logic        drd_o,
    output logic        dwr_o,
    input  logic [31:0] drdata_i,
    input  logic        dack_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_value_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e      state_q;
    logic        load_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] wb_value_q;
    logic [4:0]  wb_rd_q;
    logic        misalign_q;

    logic        ex_req;
    logic [1:0]  ex_size_n;
    logic        misaligned;
    logic        accept;
    logic        reject;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic [3:0]  mask;
    logic        in_bus;

    assign ex_req    = ex_valid_i & (ex_load_i | ex_store_i);
    assign ex_size_n = (ex_size_i == 2'd3) ? 2'd2 : ex_size_i;
    assign misaligned = ((ex_size_n == 2'd1) & ex_addr_i[0]) |
                        ((ex_size_n == 2'd2) & (|ex_addr_i[1:0]));
    assign accept    = (state_q == StIdle) & ex_req & ~misaligned;
    assign reject    = (state_q == StIdle) & ex_req & misaligned;
    assign in_bus    = (state_q == StBus);

    // Shift the addressed lane down to bit 0 before extending.
    assign lane = drdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = lane;
        mask     = 4'b1111;
        dwdata_o = wdata_q;
        case (size_q)
            2'd0: begin
                load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
                mask     = 4'b0001 << addr_q[1:0];
                dwdata_o = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
                mask     = 4'b0011 << addr_q[1:0];
                dwdata_o = {2{wdata_q[15:0]}};
            end
            default: begin
                load_ext = lane;
                mask     = 4'b1111;
                dwdata_o = wdata_q;
            end
        endcase
    end

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tcnt_q;
    logic            bus_err_q;
    logic            timeout;

    assign timeout   = in_bus & ~dack_i & (tcnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = bus_err_q;
`else
    // TIMEOUT_CYCLES only matters in the timeout build.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            load_q     <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rd_q       <= 5'd0;
            wb_value_q <= 32'd0;
            wb_rd_q    <= 5'd0;
            misalign_q <= 1'b0;
`ifdef RISCV_LSU_TIMEOUT_EN
            tcnt_q     <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            misalign_q <= reject;
`ifdef RISCV_LSU_TIMEOUT_EN
            bus_err_q  <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        load_q  <= ex_load_i;
                        uns_q   <= ex_unsigned_i;
                        size_q  <= ex_size_n;
                        addr_q  <= ex_addr_i;
                        wdata_q <= ex_wdata_i;
                        rd_q    <= ex_rd_i;
`ifdef RISCV_LSU_TIMEOUT_EN
                        tcnt_q  <= '0;
`endif
                        state_q <= StBus;
                    end
                end
                StBus: begin
                    if (dack_i) begin
                        if (load_q) begin
                            wb_value_q <= load_ext;
                            wb_rd_q    <= rd_q;
                            state_q    <= StResp;
                        end else begin
                            state_q <= StIdle;
                        end
`ifdef RISCV_LSU_TIMEOUT_EN
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
`endif
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ex_ready_o = (state_q == StIdle);
    assign stall_o    = (state_q != StIdle) | accept;
    assign daddr_o    = {addr_q[31:2], 2'b00};
    assign dmask_o    = in_bus ? mask : 4'b0000;
    assign dsize_o    = size_q;
    assign drd_o      = in_bus & load_q;
    assign dwr_o      = in_bus & ~load_q;
    assign wb_valid_o = (state_q == StResp);
    assign wb_rd_o    = wb_rd_q;
    assign wb_value_o = wb_value_q;
    assign misalign_o = misalign_q;

endmodule
